dcpu16_marb: RTL and testbench
==============================

Name: dcpu16_marb

Overview:
- Two-master memory arbiter. Merges the core's G-bus (operand read) and F-bus (fetch/writeback) simplified-Wishbone ports onto one shared memory port (M-bus).
- Sits between the core's memory-bus block and a single-ported 64K-word RAM.
- Holds each master's ack until the core's pipeline-enable retires the access, so a master acked early is never re-served while the core stalls on the other bus.

Parameters:
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ena  in  1  core pipeline enable; high = both buses retire this cycle
- g_adr  in  AW  G-bus address
- g_stb  in  1  G-bus strobe
- g_wre  in  1  G-bus write enable (tied low by the core, but supported)
- g_dto  in  DW  G-bus write data
- g_dti  out  DW  G-bus read data
- g_ack  out  1  G-bus acknowledge
- f_adr  in  AW  F-bus address
- f_stb  in  1  F-bus strobe
- f_wre  in  1  F-bus write enable
- f_dto  in  DW  F-bus write data
- f_dti  out  DW  F-bus read data
- f_ack  out  1  F-bus acknowledge
- m_adr  out  AW  memory address
- m_stb  out  1  memory strobe
- m_wre  out  1  memory write enable
- m_dto  out  DW  memory write data
- m_dti  in  DW  memory read data
- m_ack  in  1  memory acknowledge, one-cycle pulse
- m_gnt  out  2  current grant: 00 none, 01 G, 10 F

Behaviour:
- Reset values: state IDLE; m_stb=0, m_wre=0, m_adr=0, m_dto=0, m_gnt=00; g_done=f_done=0; latched read data=0; g_ack=f_ack=0.
- FSM states: IDLE, BUSY_G, BUSY_F.
- Eligibility: eligible_x = x_stb & ~x_done.
- IDLE transitions:
  - both eligible -> fixed priority, F wins;
  - one eligible -> grant it;
  - none -> stay IDLE.
- On grant (registered at the next edge): m_adr/m_wre/m_dto <= granted master's adr/wre/dto; m_stb <= 1; state -> BUSY_x; m_gnt = x.
- BUSY_x holds m_* stable until m_ack. On m_ack:
  - state -> IDLE, m_stb <= 0, m_gnt <= 00;
  - x_dti latch <= m_dti;
  - x_done <= ~ena.
- No back-to-back issue: minimum one IDLE cycle between memory transactions.
- Ack/data outputs (combinational pass-through):
  - x_ack = x_done | (state==BUSY_x & m_ack);
  - x_dti = x_done ? latched : m_dti.
- x_done is cleared on any cycle with ena=1; ena has priority over a simultaneous set.
- Latency: master strobe seen at cycle t; m_stb at t+1; zero-wait memory acks at t+1; x_ack at t+1. One arbitration wait state minimum.
- m_ack while IDLE (stale, e.g. after reset mid-transaction): ignored, no ack forwarded.
- m_ack must not arrive before m_stb; behaviour under that violation is undefined.
- Reset mid-transaction: abandon immediately, all state to reset values, outstanding memory response dropped.
- A master whose stb drops while pending is not served. Once latched into m_*, the transaction completes regardless.
- The write path is identical to reads; x_dti is don't-care for writes, but the latch still captures m_dti.

Optional Feature:
- Macro: DCPU16_MARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register (reset = G, so F wins the first tie) is updated on each grant. When both masters are eligible, the one not last granted wins.
- Undefined: fixed F-over-G priority; no last-grant register.

Decomposition:
- Shared package dcpu16_pkg holds:
  - FSM state encoding (IDLE=2'd0, BUSY_G=2'd1, BUSY_F=2'd2);
  - grant codes (GNT_NONE, GNT_G, GNT_F).
- One natural sub-module, dcpu16_marb_port, instantiated twice. It contains:
  - the done flag, read-data latch, ack/dti output muxing, and eligibility output;
  - inputs: stb, ena, grant-active, m_ack, m_dti.

Test Plan:
- Single G read, addr 0x1234, memory returns 0xBEEF with zero wait -> m_stb one cycle after g_stb; g_ack and g_dti=0xBEEF in that cycle; m_gnt=01.
- Simultaneous G read 0x0010 and F write 0x0020 data 0xCAFE, ena low until both acked -> F served first (m_wre=1, m_dto=0xCAFE); f_ack stays high while G is served; G read of 0x0010 served next; f_ack/g_ack drop after ena=1; each address issued exactly once.
- Memory with 3 wait cycles -> m_adr/m_wre/m_dto stable for all 4 cycles of m_stb; ack forwarded only on m_ack.
- rst asserted while BUSY_F, stale m_ack arrives after reset -> all outputs at reset values; no f_ack or g_ack generated.
- With DCPU16_MARB_RR_EN, both masters request continuously for 4 transactions -> grants F,G,F,G. Without the macro -> F,F,F,F while F stays eligible.
- G strobe drops before grant while F holds the bus -> after F completes, no G transaction issued; m_stb stays 0.

Source files
------------

// File: rtl/dcpu16_pkg.sv
// Shared definitions for the dcpu16 memory arbiter.
// Holds the arbiter FSM state encoding and the m_gnt grant codes.
package dcpu16_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_G = 2'd1,
        BUSY_F = 2'd2
    } marb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_G    = 2'b01;
    localparam logic [1:0] GNT_F    = 2'b10;

endpackage

// File: rtl/dcpu16_marb_port.sv
// Per-master bookkeeping for the dcpu16 memory arbiter.
// Keeps a master's ack (and its read data) alive until the core's pipeline
// enable retires the access, and reports whether the master still needs service.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   stb         master strobe
//   ena         core pipeline enable (retires the access)
//   act         arbiter is currently serving this master
//   m_ack/m_dti memory acknowledge / read data
//   elig        master wants service and has not been served yet
//   ack/dti     acknowledge and read data presented to the master
module dcpu16_marb_port #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stb,
    input  logic          ena,
    input  logic          act,
    input  logic          m_ack,
    input  logic [DW-1:0] m_dti,
    output logic          elig,
    output logic          ack,
    output logic [DW-1:0] dti
);

    logic          done;
    logic [DW-1:0] lat;
    logic          hit;

    assign hit = act & m_ack;

    // Done flag: set by our memory ack, cleared whenever the pipeline advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
        end else if (hit) begin
            done <= 1'b1;
        end
    end

    // Read-data latch, captured on every ack (writes included).
    always_ff @(posedge clk) begin
        if (rst) begin
            lat <= '0;
        end else if (hit) begin
            lat <= m_dti;
        end
    end

    assign elig = stb & ~done;
    assign ack  = done | hit;
    assign dti  = done ? lat : m_dti;

endmodule

// File: rtl/dcpu16_marb.sv
// Two-master memory arbiter: merges the core's G-bus (operand read) and
// F-bus (fetch/writeback) onto one shared memory port.
// Optional feature macro: DCPU16_MARB_RR_EN selects round-robin arbitration;
// when undefined, F has fixed priority over G.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ena                          core pipeline enable
//   g_adr/g_stb/g_wre/g_dto      G-bus request;  g_dti/g_ack response
//   f_adr/f_stb/f_wre/f_dto      F-bus request;  f_dti/f_ack response
//   m_adr/m_stb/m_wre/m_dto      memory request (registered)
//   m_dti/m_ack                  memory response
//   m_gnt                        current grant: 00 none, 01 G, 10 F
module dcpu16_marb
    import dcpu16_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [AW-1:0] g_adr,
    input  logic          g_stb,
    input  logic          g_wre,
    input  logic [DW-1:0] g_dto,
    output logic [DW-1:0] g_dti,
    output logic          g_ack,
    input  logic [AW-1:0] f_adr,
    input  logic          f_stb,
    input  logic          f_wre,
    input  logic [DW-1:0] f_dto,
    output logic [DW-1:0] f_dti,
    output logic          f_ack,
    output logic [AW-1:0] m_adr,
    output logic          m_stb,
    output logic          m_wre,
    output logic [DW-1:0] m_dto,
    input  logic [DW-1:0] m_dti,
    input  logic          m_ack,
    output logic [1:0]    m_gnt
);

    marb_state_e   state, state_n;
    logic [AW-1:0] adr_q, adr_n;
    logic [DW-1:0] dto_q, dto_n;
    logic          wre_q, wre_n;
    logic          stb_q, stb_n;
    logic [1:0]    gnt_q, gnt_n;

    logic g_elig, f_elig;
    logic g_act, f_act;
    logic pick_f, pick_g;

    assign g_act = (state == BUSY_G);
    assign f_act = (state == BUSY_F);

    dcpu16_marb_port #(.DW(DW)) u_port_g (
        .clk   (clk),
        .rst   (rst),
        .stb   (g_stb),
        .ena   (ena),
        .act   (g_act),
        .m_ack (m_ack),
        .m_dti (m_dti),
        .elig  (g_elig),
        .ack   (g_ack),
        .dti   (g_dti)
    );

    dcpu16_marb_port #(.DW(DW)) u_port_f (
        .clk   (clk),
        .rst   (rst),
        .stb   (f_stb),
        .ena   (ena),
        .act   (f_act),
        .m_ack (m_ack),
        .m_dti (m_dti),
        .elig  (f_elig),
        .ack   (f_ack),
        .dti   (f_dti)
    );

`ifdef DCPU16_MARB_RR_EN
    // Last-grant register: 1 = F was granted last. Reset to G so F wins the first tie.
    logic last_f, last_f_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_f <= 1'b0;
        end else begin
            last_f <= last_f_n;
        end
    end

    // On a tie, the master not granted last wins.
    assign pick_f = f_elig & (~g_elig | ~last_f);
`else
    assign pick_f = f_elig;
`endif
    assign pick_g = g_elig & ~pick_f;

    // State and memory-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            adr_q <= '0;
            dto_q <= '0;
            wre_q <= 1'b0;
            stb_q <= 1'b0;
            gnt_q <= GNT_NONE;
        end else begin
            state <= state_n;
            adr_q <= adr_n;
            dto_q <= dto_n;
            wre_q <= wre_n;
            stb_q <= stb_n;
            gnt_q <= gnt_n;
        end
    end

    // Next-state: grant from IDLE, hold the request until the memory acks.
    always_comb begin
        state_n = state;
        adr_n   = adr_q;
        dto_n   = dto_q;
        wre_n   = wre_q;
        stb_n   = stb_q;
        gnt_n   = gnt_q;
`ifdef DCPU16_MARB_RR_EN
        last_f_n = last_f;
`endif
        case (state)
            IDLE: begin
                // m_ack seen here is stale and deliberately ignored.
                if (pick_f) begin
                    state_n = BUSY_F;
                    adr_n   = f_adr;
                    dto_n   = f_dto;
                    wre_n   = f_wre;
                    stb_n   = 1'b1;
                    gnt_n   = GNT_F;
`ifdef DCPU16_MARB_RR_EN
                    last_f_n = 1'b1;
`endif
                end else if (pick_g) begin
                    state_n = BUSY_G;
                    adr_n   = g_adr;
                    dto_n   = g_dto;
                    wre_n   = g_wre;
                    stb_n   = 1'b1;
                    gnt_n   = GNT_G;
`ifdef DCPU16_MARB_RR_EN
                    last_f_n = 1'b0;
`endif
                end
            end
            BUSY_G, BUSY_F: begin
                // Always return through IDLE: no back-to-back issue.
                if (m_ack) begin
                    state_n = IDLE;
                    stb_n   = 1'b0;
                    gnt_n   = GNT_NONE;
                end
            end
            default: begin
                state_n = IDLE;
                stb_n   = 1'b0;
                gnt_n   = GNT_NONE;
            end
        endcase
    end

    assign m_adr = adr_q;
    assign m_dto = dto_q;
    assign m_wre = wre_q;
    assign m_stb = stb_q;
    assign m_gnt = gnt_q;

endmodule

// File: tb/tb_dcpu16_marb.sv
// Self-checking bench for dcpu16_marb: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dcpu16_marb;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
`ifdef DCPU16_MARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ena;
    logic [AW-1:0] g_adr, f_adr, m_adr;
    logic          g_stb, g_wre, f_stb, f_wre;
    logic [DW-1:0] g_dto, f_dto, g_dti, f_dti, m_dto, m_dti;
    logic          g_ack, f_ack, m_stb, m_wre, m_ack;
    logic [1:0]    m_gnt;

    always #5 clk = ~clk;

    dcpu16_marb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto),
        .g_dti(g_dti), .g_ack(g_ack),
        .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto),
        .f_dti(f_dti), .f_ack(f_ack),
        .m_adr(m_adr), .m_stb(m_stb), .m_wre(m_wre), .m_dto(m_dto),
        .m_dti(m_dti), .m_ack(m_ack), .m_gnt(m_gnt)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which master owns the memory (0 none, 1 G, 2 F), the
    // request it issued, and each master's retired-ack bookkeeping.
    int          md_owner;
    logic [15:0] md_adr, md_dto;
    logic        md_wre;
    logic        md_done_g, md_done_f;
    logic [15:0] md_lat_g, md_lat_f;
    logic        md_last_f;

    // Memory responder with configurable wait states and a transaction log.
    logic [15:0] mem [int];
    int          mem_waits = 0;
    bit          mem_active = 1'b0;
    int          mem_cnt = 0;
    bit          stale_ack = 1'b0;
    int          stb_cycles = 0;
    logic [15:0] txn_adr [$];
    logic [1:0]  txn_gnt [$];

    task automatic compare();
        logic exp_ag, exp_af;
        exp_ag = md_done_g | (md_owner == 1 && m_ack);
        exp_af = md_done_f | (md_owner == 2 && m_ack);
        chk("m_stb", 32'(m_stb), 32'(md_owner != 0));
        chk("m_gnt", 32'(m_gnt), 32'(md_owner));
        if (md_owner != 0) begin
            chk("m_adr", 32'(m_adr), 32'(md_adr));
            chk("m_wre", 32'(m_wre), 32'(md_wre));
            chk("m_dto", 32'(m_dto), 32'(md_dto));
        end
        chk("g_ack", 32'(g_ack), 32'(exp_ag));
        chk("f_ack", 32'(f_ack), 32'(exp_af));
        if (exp_ag) chk("g_dti", 32'(g_dti), 32'(md_done_g ? md_lat_g : m_dti));
        if (exp_af) chk("f_dti", 32'(f_dti), 32'(md_done_f ? md_lat_f : m_dti));
    endtask

    task automatic model_step();
        logic ag, af, eg, ef, win_f;
        if (rst) begin
            md_owner = 0; md_adr = '0; md_dto = '0; md_wre = 1'b0;
            md_done_g = 1'b0; md_done_f = 1'b0;
            md_lat_g = '0; md_lat_f = '0; md_last_f = 1'b0;
        end else begin
            ag = (md_owner == 1) && m_ack;
            af = (md_owner == 2) && m_ack;
            eg = g_stb && !md_done_g;
            ef = f_stb && !md_done_f;
            if (ag) md_lat_g = m_dti;
            if (af) md_lat_f = m_dti;
            md_done_g = ena ? 1'b0 : (md_done_g | ag);
            md_done_f = ena ? 1'b0 : (md_done_f | af);
            if (md_owner != 0) begin
                if (m_ack) md_owner = 0;
            end else if (ef || eg) begin
                win_f = ef && (!eg || !RR || !md_last_f);
                md_owner  = win_f ? 2 : 1;
                md_adr    = win_f ? f_adr : g_adr;
                md_dto    = win_f ? f_dto : g_dto;
                md_wre    = win_f ? f_wre : g_wre;
                md_last_f = win_f;
            end
        end
    endtask

    // First half of a cycle: memory responds, outputs settle, model compare.
    task automatic step_a();
        m_ack = 1'b0;
        m_dti = 16'($urandom);
        if (stale_ack) begin
            m_ack = 1'b1;
            m_dti = 16'hDEAD;
        end else if (m_stb) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_cnt = mem_waits;
                txn_adr.push_back(m_adr);
                txn_gnt.push_back(m_gnt);
            end
            if (mem_cnt == 0) begin
                m_ack = 1'b1;
                if (m_wre) mem[int'(m_adr)] = m_dto;
                else m_dti = mem.exists(int'(m_adr)) ? mem[int'(m_adr)] : (m_adr ^ 16'h5A5A);
                mem_active = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
        if (m_stb === 1'b1) stb_cycles++;
        if (cmp_en) compare();
    endtask

    // Second half: advance model and clock.
    task automatic step_b();
        model_step();
        @(posedge clk);
        #1;
        if (rst) mem_active = 1'b0;
    endtask

    task automatic cycle();
        step_a();
        step_b();
    endtask

    task automatic quiet();
        g_stb = 1'b0; f_stb = 1'b0; g_wre = 1'b0; f_wre = 1'b0;
        g_adr = '0; f_adr = '0; g_dto = '0; f_dto = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1; ena = 1'b1; m_ack = 1'b0; m_dti = '0;
        quiet();
        @(posedge clk); #1;
        cycle();
        cmp_en = 1'b1;
        rst = 1'b0;
        // Reset values
        chk("rst_m_stb", 32'(m_stb), 32'd0);
        chk("rst_m_gnt", 32'(m_gnt), 32'd0);
        chk("rst_m_adr", 32'(m_adr), 32'd0);
        chk("rst_m_wre", 32'(m_wre), 32'd0);
        chk("rst_m_dto", 32'(m_dto), 32'd0);
        chk("rst_g_ack", 32'(g_ack), 32'd0);
        chk("rst_f_ack", 32'(f_ack), 32'd0);
        cycle();

        // Single zero-wait G read
        mem[32'h1234] = 16'hBEEF;
        mem_waits = 0;
        g_stb = 1'b1; g_adr = 16'h1234;
        cycle();
        g_stb = 1'b0;
        step_a();
        chk("t1_m_stb", 32'(m_stb), 32'd1);
        chk("t1_m_gnt", 32'(m_gnt), 32'h1);
        chk("t1_m_adr", 32'(m_adr), 32'h1234);
        chk("t1_g_ack", 32'(g_ack), 32'd1);
        chk("t1_g_dti", 32'(g_dti), 32'hBEEF);
        step_b();
        repeat (2) cycle();

        // Simultaneous G read and F write with ena held low
        mem[32'h0010] = 16'h1111;
        n0 = txn_adr.size();
        ena = 1'b0;
        g_stb = 1'b1; g_adr = 16'h0010;
        f_stb = 1'b1; f_adr = 16'h0020; f_wre = 1'b1; f_dto = 16'hCAFE;
        cycle();
        step_a();
        chk("t2_f_gnt", 32'(m_gnt), 32'h2);
        chk("t2_f_wre", 32'(m_wre), 32'd1);
        chk("t2_f_dto", 32'(m_dto), 32'hCAFE);
        chk("t2_f_ack", 32'(f_ack), 32'd1);
        step_b();
        step_a();
        chk("t2_f_hold_idle", 32'(f_ack), 32'd1);
        step_b();
        step_a();
        chk("t2_g_gnt", 32'(m_gnt), 32'h1);
        chk("t2_f_hold_g", 32'(f_ack), 32'd1);
        chk("t2_g_ack", 32'(g_ack), 32'd1);
        chk("t2_g_dti", 32'(g_dti), 32'h1111);
        step_b();
        ena = 1'b1;
        quiet();
        step_a();
        chk("t2_g_ack_held", 32'(g_ack), 32'd1);
        chk("t2_g_dti_held", 32'(g_dti), 32'h1111);
        step_b();
        step_a();
        chk("t2_g_ack_drop", 32'(g_ack), 32'd0);
        chk("t2_f_ack_drop", 32'(f_ack), 32'd0);
        step_b();
        cycle();
        chk("t2_txn_count", 32'(txn_adr.size() - n0), 32'd2);
        if (txn_adr.size() >= n0 + 2) begin
            chk("t2_first_adr", 32'(txn_adr[n0]), 32'h0020);
            chk("t2_second_adr", 32'(txn_adr[n0+1]), 32'h0010);
        end

        // Three wait states on an F read
        mem_waits = 3;
        f_stb = 1'b1; f_adr = 16'h0300;
        cycle();
        quiet();
        stb_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            step_a();
            chk("t3_f_ack", 32'(f_ack), 32'(k == 3));
            chk("t3_m_adr", 32'(m_adr), 32'h0300);
            step_b();
        end
        repeat (2) cycle();
        chk("t3_stb_cycles", 32'(stb_cycles), 32'd4);

        // Reset while BUSY_F, then a stale memory ack
        mem_waits = 5;
        f_stb = 1'b1; f_adr = 16'h0400;
        cycle();
        quiet();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        stale_ack = 1'b1;
        step_a();
        chk("t4_m_stb", 32'(m_stb), 32'd0);
        chk("t4_m_gnt", 32'(m_gnt), 32'd0);
        chk("t4_m_adr", 32'(m_adr), 32'd0);
        chk("t4_f_ack", 32'(f_ack), 32'd0);
        chk("t4_g_ack", 32'(g_ack), 32'd0);
        step_b();
        stale_ack = 1'b0;
        step_a();
        chk("t4_f_ack_after", 32'(f_ack), 32'd0);
        step_b();

        // Both masters requesting continuously
        mem_waits = 0;
        n0 = txn_adr.size();
        g_stb = 1'b1; g_adr = 16'h0500;
        f_stb = 1'b1; f_adr = 16'h0501;
        repeat (8) cycle();
        quiet();
        repeat (2) cycle();
        chk("t5_txn_count", 32'(txn_adr.size() - n0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (txn_gnt.size() > n0 + i)
                chk($sformatf("t5_grant%0d", i), 32'(txn_gnt[n0+i]),
                    32'((RR && (i % 2 == 1)) ? 2'b01 : 2'b10));
        end

        // G strobe withdrawn while F holds the bus
        mem_waits = 2;
        n0 = txn_adr.size();
        f_stb = 1'b1; f_adr = 16'h0600;
        cycle();
        f_stb = 1'b0;
        g_stb = 1'b1; g_adr = 16'h0700;
        cycle();
        g_stb = 1'b0;
        repeat (6) cycle();
        chk("t6_txn_count", 32'(txn_adr.size() - n0), 32'd1);
        chk("t6_m_stb", 32'(m_stb), 32'd0);
        if (txn_adr.size() > n0) chk("t6_adr", 32'(txn_adr[n0]), 32'h0600);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 79) == 0);
            ena   = ($urandom_range(0, 9) < 6);
            g_stb = 1'($urandom); g_wre = ($urandom_range(0, 7) == 0);
            g_adr = 16'($urandom); g_dto = 16'($urandom);
            f_stb = 1'($urandom); f_wre = 1'($urandom);
            f_adr = 16'($urandom); f_dto = 16'($urandom);
            mem_waits = $urandom_range(0, 3);
            cycle();
        end
        rst = 1'b0; ena = 1'b1;
        quiet();
        repeat (8) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
